// File: rtl/sa_result_deskew.sv
// Output-side de-skew buffer for an N x N systolic array: captures the
// column-skewed y_out stream and hands whole result rows downstream over valid/ready.
module sa_result_deskew #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] y_in [0:N-1],
  output logic [W-1:0] out_row [0:N-1],
  output logic         out_valid,
  input  logic         out_ready,
  output logic         idle,
  output logic         done,
  output logic         err
);

  localparam int TW     = $clog2(2 * N);
  localparam int CW     = $clog2(N + 1);
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam int LAST_T = 2 * N - 2;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d, cap_t;
  logic [CW-1:0] rows_q, rows_d, rd_q, rd_d;
  logic          done_d;
  logic          capturing;
  logic          xfer;
  logic [W-1:0]  mem [N][N];

  // The start cycle is itself capture cycle t = 0, so capture also runs from IDLE.
  assign idle      = (state_q == IDLE);
  assign capturing = (idle && start) || (state_q == CAPTURE);
  assign cap_t     = idle ? '0 : t_q;
  assign out_valid = (rd_q < rows_q);
  assign xfer      = out_valid && out_ready;

  always_comb begin
    for (int j = 0; j < N; j++) out_row[j] = mem[rd_q[IW-1:0]][j];
  end

  // NOTE: the row buffer sits on the async reset because the outputs must read
  // back as zero straight out of reset; a plain RAM without reset would not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) mem[r][c] <= '0;
    end else if (capturing) begin
      for (int j = 0; j < N; j++)
        if (int'(cap_t) >= j && int'(cap_t) - j < N)
          mem[IW'(int'(cap_t) - j)][j] <= y_in[j];
    end
  end

  // NOTE: every signal gets its hold value first so no path through this block
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    rows_d  = rows_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    if (capturing) begin
      if (int'(cap_t) >= N - 1) rows_d = rows_q + CW'(1);
      if (int'(cap_t) == LAST_T) begin
        state_d = DRAIN;
        t_d     = '0;
      end else begin
        state_d = CAPTURE;
        t_d     = cap_t + TW'(1);
      end
    end
    // The final row can only become valid after capture ends, so this
    // retirement never collides with the capture update above.
    if (xfer) begin
      if (int'(rd_q) == N - 1) begin
        state_d = IDLE;
        t_d     = '0;
        rows_d  = '0;
        rd_d    = '0;
        done_d  = 1'b1;
      end else begin
        rd_d = rd_q + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      rows_q  <= '0;
      rd_q    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      rows_q  <= rows_d;
      rd_q    <= rd_d;
      done    <= done_d;
      err     <= err | (start && !idle);
    end
  end

endmodule

// File: doc/sa_result_deskew.md
# sa_result_deskew

Output-side companion to the N×N systolic array. The block captures the array's column-skewed result stream (`y_out`, where column j lags column 0 by j cycles) and rebuilds whole result-matrix rows. It then hands those rows, one row per transfer, to a downstream consumer over a valid/ready handshake. It performs the inverse of the diagonal skew applied to activations on the input side, and it buffers a full matrix so that downstream backpressure never stalls the free-running array.

## Interface
Parameters:
- `N`, default 4: array dimension. Sets the number of result rows and columns.
- `W`, default 8: element width, matching the array `y_out` width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low. All state clears while low.
- `start`, input, 1: one-cycle pulse, asserted in the same cycle as the first column-0 result on `y_in[0]`.
- `y_in[0:N-1]`, input, W each: skewed result columns from the array.
- `out_row[0:N-1]`, output, W each: de-skewed result row.
- `out_valid`, output, 1: `out_row` holds a complete row.
- `out_ready`, input, 1: consumer accepts the row.
- `idle`, output, 1: no capture in progress and all rows have been drained.
- `done`, output, 1: one-cycle pulse after the last row of a matrix is transferred.
- `err`, output, 1: sticky overrun flag, set when `start` arrives while `idle` is 0.

## Operation
- **State:** an N×N×W row buffer, a capture counter `t` (0..2N-2), a completed-row count `rows_ok` (0..N), and a read pointer `rd` (0..N).
- **Reset values:** buffer = 0, `t` = 0, `rows_ok` = 0, `rd` = 0, `out_valid` = 0, `out_row` = 0, `idle` = 1, `done` = 0, `err` = 0.
- **State machine:**
  - IDLE: `start` moves to CAPTURE, with `t` = 0 in the `start` cycle itself.
  - CAPTURE: after cycle `t` = 2N-2, moves to DRAIN.
  - DRAIN: when `rd` = N, moves to IDLE and pulses `done`.
  - Rows may drain during CAPTURE; DRAIN is only the post-capture tail.
- **Capture rule:** in capture cycle `t`, for each column j with 0 ≤ t-j ≤ N-1, write `y_in[j]` to `buf[t-j][j]`. All other columns are ignored in that cycle.
- **Row completion:** row r completes at `t` = r+N-1, and `rows_ok` increments on that edge.
- **Output:** `out_valid` = (`rd` < `rows_ok`); `out_row` = `buf[rd]`. A transfer occurs when `out_valid` and `out_ready` are both high, and `rd` increments on that edge.
- **Stability:** while `out_valid` is high and `out_ready` is low, `out_row` must hold stable. The buffer entry for row `rd` is never rewritten within a matrix.
- **Overrun:** `start` while `idle` = 0 is ignored (the capture is not restarted) and sets `err`. Only reset clears `err`.
- **No arithmetic on data:** values pass through bit-exact; there is no width change.
- **`out_ready` outside a valid row:** `out_ready` high while `out_valid` is low has no effect.

## Timing
- Let S be the cycle in which `start` is sampled high.
- Row 0 becomes valid in cycle S+N. Row r is valid no earlier than S+N+r.
- The last `y_in` sample is taken in cycle S+2N-2; columns outside their window are don't-care.
- With `out_ready` held high, rows transfer in cycles S+N through S+2N-1. `done` is high in cycle S+2N, and `idle` returns to 1 in that same cycle.
- With `out_ready` low throughout capture, all N rows remain buffered. Draining then resumes at one row per cycle.
- `idle` goes low in the cycle after S. A new `start` is accepted from the first cycle in which `idle` = 1 again.
- Reset asserted mid-operation clears all state immediately (asynchronous). After reset deasserts, `y_in` is ignored until the next `start`.

## Test plan
- **Nominal capture, `out_ready` = 1.** Drive the skewed stream of C = [[7,14,21,28],[9,18,27,36],[8,16,24,32],[10,20,30,40]], N = 4. Expect rows in that order in cycles S+4 through S+7, `done` in S+8, `err` = 0.
- **Backpressure.** Same stimulus with `out_ready` = 0 until S+10, then 1. Expect `out_valid` = 1 with `out_row` = [7,14,21,28] held from S+4 to S+10, then the remaining rows in consecutive cycles and `done` in S+14.
- **Intermittent ready.** Toggle `out_ready` every cycle. Expect each row transferred exactly once, in order, with no duplicates or drops.
- **Skew masking.** Drive 0xFF on out-of-window column slots, for example `y_in[3]` at `t` = 0..2. Expect the output rows to be unchanged from the nominal case.
- **Overrun.** Pulse `start` again at S+3. Expect `err` = 1 sticky, the first matrix output intact, and no restart of the capture.
- **Mid-operation reset.** Drive `rst` low at S+5. Expect the asynchronous clear: `out_valid` = 0, `idle` = 1, `done` = 0. After release, a fresh nominal run must produce the correct rows.
